// File: rtl/uart_tx_serializer_if.sv
// Handshake bundle between the transmit FIFO side and the UART serializer.
//   tx_start     : request to send din (producer -> serializer)
//   din          : word to transmit (producer -> serializer)
//   tx_ready     : serializer idle and able to accept a word
//   tx_done_tick : one-clk pulse on the final stop tick of a frame
interface uart_tx_serializer_if #(
  parameter int DBIT = 8
);
  logic            tx_start;
  logic [DBIT-1:0] din;
  logic            tx_ready;
  logic            tx_done_tick;

  modport master (output tx_start, din, input tx_ready, tx_done_tick);
  modport slave  (input tx_start, din, output tx_ready, tx_done_tick);
endinterface

// File: rtl/uart_tx_serializer.sv
// Tick-driven UART transmitter. Shifts one word out LSB-first as
// start bit, DBIT data bits, optional parity bit and SB_TICK ticks of stop,
// each start/data/parity bit lasting 16 s_tick pulses.
//   clk    : system clock
//   reset  : asynchronous, active-high
//   s_tick : one-clk pulse at 16x the baud rate
//   bus    : tx_start/din in, tx_ready/tx_done_tick out
//   tx     : registered serial line, idle high
//
// state | meaning
// IDLE  | line high, waiting for tx_start
// START | driving start bit (0) for 16 ticks
// DATA  | driving b_q[0], shifting every 16 ticks
// PAR   | driving parity bit for 16 ticks
// STOP  | line high for SB_TICK ticks
module uart_tx_serializer #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_tick,
  uart_tx_serializer_if.slave   bus,
  output logic                  tx
);
  localparam int SW = (SB_TICK > 16) ? 5 : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [SW-1:0] BIT_LAST  = SW'(15);
  localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   s_cnt_q, s_cnt_d;
  logic [NW-1:0]   n_cnt_q, n_cnt_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            p_q, p_d;
  logic            tx_q, tx_d;
  logic            ready_q, ready_d;

  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    b_d     = b_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (bus.tx_start) begin
          b_d     = bus.din;
          s_cnt_d = '0;
          p_d     = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt_q == BIT_LAST) begin
            s_cnt_d = '0;
            n_cnt_d = '0;
            state_d = DATA;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt_q == BIT_LAST) begin
            s_cnt_d = '0;
            p_d     = p_q ^ b_q[0];
            b_d     = b_q >> 1;
            if (n_cnt_q == N_LAST) begin
              state_d = (PARITY != 0) ? PAR : STOP;
            end else begin
              n_cnt_d = n_cnt_q + NW'(1);
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
      PAR: begin
        if (s_tick) begin
          if (s_cnt_q == BIT_LAST) begin
            s_cnt_d = '0;
            state_d = STOP;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_cnt_q == STOP_LAST) begin
            s_cnt_d = '0;
            state_d = IDLE;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The line level is derived from the next state so that tx moves on the
    // same edge as the state change, i.e. right after the 16th tick of a bit.
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = b_d[0];
      PAR:     tx_d = (PARITY == 2) ? ~p_d : p_d;
      default: tx_d = 1'b1;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      b_q     <= '0;
      p_q     <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      b_q     <= b_d;
      p_q     <= p_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
    end
  end

  // Done must coincide with the final stop tick itself, so it is decoded
  // from registered state and the live tick rather than registered again.
  assign bus.tx_done_tick = (state_q == STOP) && s_tick && (s_cnt_q == STOP_LAST);
  assign bus.tx_ready     = ready_q;
  assign tx               = tx_q;
endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;
  typedef struct {
    logic [7:0] data;
    int         acc;
    bit         b2b;
  } frame_t;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         gap;
  } op_t;

  localparam int OP_SEND = 0;
  localparam int OP_BUSY = 1;
  localparam int OP_HOLD = 2;
  localparam int OP_RST  = 3;
  localparam int OP_GATE = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   tcnt = 0;
  logic s_tick_base;
  always @(posedge clk) tcnt <= (tcnt == 7) ? 0 : tcnt + 1;
  assign s_tick_base = (tcnt == 7);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h t=%0t", name, act, exp_v, $time);
    end
  endtask

  // Line level of frame bit idx: 0 start, 1..8 data LSB first, 9 parity when
  // enabled, everything afterwards stop (high).
  function automatic logic exp_level(input int idx, input logic [7:0] d, input int par);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (idx == 9 && par == 1) return ($countones(d) % 2) == 1;
    if (idx == 9 && par == 2) return ($countones(d) % 2) == 0;
    return 1'b1;
  endfunction

  for (genvar l = 0; l < 3; l++) begin : g_lane
    localparam int P     = (l == 0) ? 0 : (l == 1) ? 1 : 2;
    localparam int SB    = (l == 0) ? 16 : (l == 1) ? 24 : 32;
    localparam int NBITS = 9 + ((P != 0) ? 1 : 0);
    localparam int TOT   = 16 * NBITS + SB;

    logic   rst_l    = 1'b1;
    logic   tick_en  = 1'b1;
    logic   done     = 1'b0;
    logic   mon_busy = 1'b0;
    logic   tx_l;
    logic   s_tick_l;
    frame_t q[$];

    uart_tx_serializer_if #(.DBIT(8)) bus ();
    assign s_tick_l = s_tick_base & tick_en;

    uart_tx_serializer #(.DBIT(8), .SB_TICK(SB), .PARITY(P)) dut (
      .clk   (clk),
      .reset (rst_l),
      .s_tick(s_tick_l),
      .bus   (bus),
      .tx    (tx_l)
    );

    initial begin : drv
      op_t        ops[$];
      int         w;
      int         n;
      logic [7:0] v;
      bus.tx_start = 1'b0;
      bus.din      = '0;
      ops.push_back('{OP_SEND, 8'h55, 5});
      ops.push_back('{OP_SEND, 8'h00, 0});
      ops.push_back('{OP_SEND, 8'hFF, 3});
      ops.push_back('{OP_SEND, 8'h5A, 0});
      ops.push_back('{OP_SEND, 8'hA5, 7});
      ops.push_back('{OP_SEND, 8'h07, 2});
      ops.push_back('{OP_BUSY, 8'hA3, 30});
      ops.push_back('{OP_HOLD, 8'($urandom), 4});
      ops.push_back('{OP_RST,  8'hF0, 2});
      ops.push_back('{OP_SEND, 8'h3C, 6});
      ops.push_back('{OP_GATE, 8'($urandom), 1});
      for (int i = 0; i < 8; i++)
        ops.push_back('{OP_SEND, 8'($urandom), int'($urandom_range(0, 20))});

      repeat (3) @(negedge clk);
      rst_l = 1'b0;
      @(negedge clk);
      chk($sformatf("l%0d_reset_tx", l), tx_l, 1);
      chk($sformatf("l%0d_reset_ready", l), bus.tx_ready, 1);
      chk($sformatf("l%0d_reset_done", l), bus.tx_done_tick, 0);

      foreach (ops[i]) begin
        v = ops[i].data;
        w = 0;
        while (bus.tx_ready !== 1'b1 && w < 5000) begin
          @(negedge clk);
          w++;
        end
        chk($sformatf("l%0d_op%0d_ready_wait", l, i), bus.tx_ready, 1);
        bus.tx_start = 1'b1;
        bus.din      = v;
        q.push_back('{v, cyc, 1'b0});
        if (ops[i].kind == OP_HOLD) begin
          n = 0;
          w = 0;
          while (n == 0 && w < 5000) begin
            @(negedge clk);
            w++;
            if (bus.tx_ready === 1'b1) begin
              q.push_back('{v, cyc, 1'b1});
              n = 1;
            end
          end
          chk($sformatf("l%0d_hold_second_accept", l), n, 1);
        end
        @(negedge clk);
        bus.tx_start = 1'b0;
        bus.din      = 8'($urandom);

        if (ops[i].kind == OP_BUSY || ops[i].kind == OP_GATE || ops[i].kind == OP_RST) begin
          n = 0;
          while (n < ((ops[i].kind == OP_RST) ? 72 : 40)) begin
            if (s_tick_l) n++;
            if (n < ((ops[i].kind == OP_RST) ? 72 : 40)) @(negedge clk);
          end
        end
        if (ops[i].kind == OP_BUSY) begin
          @(negedge clk);
          bus.tx_start = 1'b1;
          bus.din      = 8'hFF;
          @(negedge clk);
          bus.tx_start = 1'b0;
        end
        if (ops[i].kind == OP_GATE) begin
          repeat (3) @(negedge clk);
          @(posedge clk);
          #1 tick_en = 1'b0;
          repeat (100) @(posedge clk);
          #1 tick_en = 1'b1;
        end
        if (ops[i].kind == OP_RST) begin
          chk($sformatf("l%0d_rst_pre_tx", l), tx_l, 0);
          #2 rst_l = 1'b1;
          #1;
          chk($sformatf("l%0d_rst_async_tx", l), tx_l, 1);
          chk($sformatf("l%0d_rst_ready", l), bus.tx_ready, 1);
          chk($sformatf("l%0d_rst_done", l), bus.tx_done_tick, 0);
          repeat (3) @(negedge clk);
          rst_l = 1'b0;
          @(negedge clk);
          chk($sformatf("l%0d_post_rst_ready", l), bus.tx_ready, 1);
          chk($sformatf("l%0d_post_rst_done", l), bus.tx_done_tick, 0);
        end
        repeat (ops[i].gap) @(negedge clk);
      end

      w = 0;
      while ((q.size() != 0 || mon_busy) && w < 20000) begin
        @(negedge clk);
        w++;
      end
      chk($sformatf("l%0d_drain_queue", l), q.size(), 0);
      chk($sformatf("l%0d_drain_monitor", l), mon_busy, 0);
      done = 1'b1;
    end

    initial begin : mon
      frame_t     f;
      int         k;
      int         w;
      int         done_cyc;
      int         last_done;
      logic       ok;
      logic       aborted;
      logic       lvl;
      logic       rxp;
      logic [7:0] rx;
      last_done = -100;
      forever begin
        @(negedge clk);
        if (rst_l === 1'b0 && tx_l === 1'b0) begin
          if (q.size() == 0) begin
            chk($sformatf("l%0d_unexpected_frame", l), tx_l, 1);
            w = 0;
            while (bus.tx_done_tick !== 1'b1 && rst_l !== 1'b1 && w < 4000) begin
              @(negedge clk);
              w++;
            end
          end else begin
            f        = q.pop_front();
            mon_busy = 1'b1;
            chk($sformatf("l%0d_accept_latency", l), cyc, f.acc + 1);
            if (f.b2b) chk($sformatf("l%0d_b2b_gap", l), cyc - last_done, 2);
            k        = 0;
            w        = 0;
            ok       = 1'b1;
            aborted  = 1'b0;
            rx       = '0;
            rxp      = 1'b0;
            done_cyc = -1;
            while (k < TOT && !aborted && w < 4000) begin
              if (rst_l) begin
                aborted = 1'b1;
              end else begin
                lvl = exp_level(k / 16, f.data, P);
                if (tx_l !== lvl) ok = 1'b0;
                if (s_tick_l) begin
                  if (k % 16 == 8) begin
                    if (k / 16 >= 1 && k / 16 <= 8) rx[k/16-1] = tx_l;
                    if (k / 16 == 9) rxp = tx_l;
                  end
                  if (bus.tx_done_tick !== (k == TOT - 1)) ok = 1'b0;
                  if (k == TOT - 1) done_cyc = cyc;
                  k++;
                end else if (bus.tx_done_tick !== 1'b0) begin
                  ok = 1'b0;
                end
                if (k < TOT) begin
                  @(negedge clk);
                  w++;
                end
              end
            end
            if (!aborted) begin
              if (k < TOT) begin
                chk($sformatf("l%0d_frame_timeout", l), k, TOT);
              end else begin
                chk($sformatf("l%0d_wave_%02h", l, f.data), ok, 1);
                chk($sformatf("l%0d_data", l), rx, f.data);
                chk($sformatf("l%0d_bit9", l), rxp, exp_level(9, f.data, P));
                last_done = done_cyc;
                @(negedge clk);
                chk($sformatf("l%0d_ready_after_done", l), bus.tx_ready, 1);
                chk($sformatf("l%0d_idle_tx", l), tx_l, 1);
              end
            end
            mon_busy = 1'b0;
          end
        end
      end
    end
  end

  initial begin : top
    int w;
    w = 0;
    while (!(g_lane[0].done && g_lane[1].done && g_lane[2].done) && w < 90000) begin
      @(negedge clk);
      w++;
    end
    if (!(g_lane[0].done && g_lane[1].done && g_lane[2].done)) begin
      total++;
      bad++;
      $display("FAIL watchdog: lanes unfinished after %0d cycles", w);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
